// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding encodings, FSM states, scoreboard entries.
// Purely declarative; no latency or backpressure of its own.
package pipe_pkg;

    // Register indices up to 8 bits are zero-extended into the scoreboard.
    localparam int SB_DST_W = 8;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_ME   = 2'b10;
    localparam logic [1:0] FWD_MELD = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } hazState_t;

    typedef struct packed {
        logic                valid;
        logic                regWrite;
        logic                memToReg;
        logic [SB_DST_W-1:0] dst;
    } sbEntry_t;

    function automatic logic sbHit(input sbEntry_t e, input logic [SB_DST_W-1:0] src, input logic uses);
        return uses && e.valid && e.regWrite && (e.dst != '0) && (e.dst == src);
    endfunction

    // A load still in EX is the newest producer; its data is not ready, so the older ME value
    // must not be used. The load-use stall covers that cycle.
    function automatic logic [1:0] fwdPick(input logic hitEx, input logic exLoad,
                                           input logic hitMe, input logic meLoad);
        if (hitEx)
            return exLoad ? FWD_RF : FWD_EX;
        if (hitMe)
            return meLoad ? FWD_MELD : FWD_ME;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One registered scoreboard stage; priority hold > bubble > load, one-cycle update.
// Hold freezes the entry while the pipeline is stalled.
module hazard_sb_entry
    import pipe_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     hold,
    input  logic     bubble,
    input  logic     load,
    input  sbEntry_t d,
    output sbEntry_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (!hold) begin
            if (bubble)
                q <= '0;
            else if (load)
                q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard controller for the 5-stage pipe: stall, IF/ID flush, EX bubble and forwarding selects.
// Controls are combinational from decode plus the EX/ME shadow scoreboard; ex_busy freezes everything.
module pipe_hazard_ctl
    import pipe_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int FLUSH_CYC    = 1,
    parameter int MAX_EX_STALL = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic [REG_W-1:0] id_write_reg,
    input  logic             ex_busy,
    input  logic             branch_taken_ex,
    input  logic             jump_id,
    output logic             any_stall,
    output logic             flush_if,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             watchdog_err,
    output logic [1:0]       state
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int WD_W = $clog2(MAX_EX_STALL + 1);
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(MAX_EX_STALL);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(MAX_EX_STALL - 1);

    sbEntry_t                sbEx, sbMe, decEntry;
    logic [SB_DST_W-1:0]     srcA, srcB;
    logic                    hitExA, hitExB, hitMeA, hitMeB;
    logic                    loadUse;
    logic [1:0]              fwdA, fwdB;
    logic                    flushIfPrev;
    hazState_t               stateQ, stateNxt;
    logic [FC_W-1:0]         flushCntQ, flushCntNxt;
    logic [WD_W-1:0]         wdCntQ;
    logic                    wdErrQ;

    // Decode entry; an instruction sitting behind last cycle's flush is already squashed.
    always_comb begin
        decEntry          = '0;
        decEntry.valid    = id_valid & ~flushIfPrev;
        decEntry.regWrite = id_reg_write;
        decEntry.memToReg = id_mem_to_reg;
        decEntry.dst      = SB_DST_W'(id_write_reg);
    end

    assign srcA   = SB_DST_W'(id_rs);
    assign srcB   = SB_DST_W'(id_rt);
    assign hitExA = sbHit(sbEx, srcA, id_uses_rs);
    assign hitExB = sbHit(sbEx, srcB, id_uses_rt);
    assign hitMeA = sbHit(sbMe, srcA, id_uses_rs);
    assign hitMeB = sbHit(sbMe, srcB, id_uses_rt);

    assign loadUse = id_valid & (hitExA | hitExB) & sbEx.memToReg;
    assign fwdA    = fwdPick(hitExA, sbEx.memToReg, hitMeA, sbMe.memToReg);
    assign fwdB    = fwdPick(hitExB, sbEx.memToReg, hitMeB, sbMe.memToReg);

    // A taken branch or a load-use hazard inserts a bubble behind EX; ME always follows EX.
    hazard_sb_entry uSbEx (
        .clk    (clk),
        .reset  (reset),
        .hold   (ex_busy),
        .bubble (branch_taken_ex | loadUse),
        .load   (1'b1),
        .d      (decEntry),
        .q      (sbEx)
    );

    hazard_sb_entry uSbMe (
        .clk    (clk),
        .reset  (reset),
        .hold   (ex_busy),
        .bubble (1'b0),
        .load   (1'b1),
        .d      (sbEx),
        .q      (sbMe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= ST_RUN;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateNxt;
            flushCntQ <= flushCntNxt;
        end
    end

    // flushCntQ counts FLUSH cycles still to come, including the current one.
    always_comb begin
        stateNxt    = ST_RUN;
        flushCntNxt = '0;
        if (ex_busy) begin
            stateNxt = ST_FREEZE;
        end else if (branch_taken_ex) begin
            if (FLUSH_CYC > 1) begin
                stateNxt    = ST_FLUSH;
                flushCntNxt = FC_RELOAD;
            end
        end else if (stateQ == ST_FLUSH && flushCntQ > FC_ONE) begin
            stateNxt    = ST_FLUSH;
            flushCntNxt = flushCntQ - FC_ONE;
        end
    end

    always_comb begin
        any_stall = 1'b0;
        flush_if  = 1'b0;
        bubble_ex = 1'b0;
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (!reset) begin
            fwd_a_sel = fwdA;
            fwd_b_sel = fwdB;
            if (ex_busy) begin
                any_stall = 1'b1;
            end else if (branch_taken_ex) begin
                flush_if  = 1'b1;
                bubble_ex = 1'b1;
            end else begin
                any_stall = loadUse;
                bubble_ex = loadUse;
                // A jump held behind a load-use stall is re-presented next cycle.
                flush_if  = (stateQ == ST_FLUSH) | (jump_id & ~loadUse);
            end
        end
    end

    assign state = stateQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flushIfPrev <= 1'b0;
        else
            flushIfPrev <= flush_if;
    end

    // The watchdog saturates at MAX_EX_STALL; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdCntQ <= '0;
            wdErrQ <= 1'b0;
        end else if (ex_busy) begin
            if (wdCntQ != WD_MAX)
                wdCntQ <= wdCntQ + 1'b1;
            if (wdCntQ == WD_LAST)
                wdErrQ <= 1'b1;
        end else begin
            wdCntQ <= '0;
        end
    end

    assign watchdog_err = wdErrQ;

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/ME/WB). It keeps its own shadow scoreboard of the destinations held in EX and ME. From that scoreboard it drives the global stall, IF/ID flush, EX bubble injection and operand-forwarding selects. It replaces the constant-zero stall and redirect ties at the top level, and resolves multi-cycle EX ops, load-use hazards, taken branches and jumps.

Parameters:
REG_W, 5, register-index width
FLUSH_CYC, 1, cycles flush_if stays asserted after a taken branch (>=1)
MAX_EX_STALL, 32, consecutive ex_busy cycles before watchdog_err sets

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
id_valid  in  1  decode holds a real instruction
id_rs  in  REG_W  decode source A index
id_rt  in  REG_W  decode source B index
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_reg_write  in  1  decode instruction writes a register
id_mem_to_reg  in  1  decode instruction is a load
id_write_reg  in  REG_W  decode destination index
ex_busy  in  1  multi-cycle op occupying EX
branch_taken_ex  in  1  branch in EX resolved taken
jump_id  in  1  jump in decode
any_stall  out  1  freeze PC, IF/ID, ID/EX, EX/ME
flush_if  out  1  squash IF/ID register contents
bubble_ex  out  1  load a bubble into ID/EX
fwd_a_sel  out  2  00 regfile, 01 EX result, 10 ME result, 11 ME load data
fwd_b_sel  out  2  same encoding for source B
watchdog_err  out  1  sticky EX-timeout flag
state  out  2  FSM state (debug)

Behaviour:
- Scoreboard entries SB_EX and SB_ME, each holding {valid, reg_write, mem_to_reg, dst}. Reset clears both.
- Hit(src, e) requires all of: e.valid, e.reg_write, e.dst != 0, e.dst == src, and the matching id_uses_* set.
- Forwarding is combinational:
  - SB_EX hit, non-load -> 01.
  - Otherwise SB_ME hit -> 10 if not a load, 11 if a load.
  - Otherwise 00.
  - EX has priority over ME. Register 0 never forwards.
- Load-use condition: SB_EX hit with mem_to_reg on either used source, and id_valid.
- FSM states: RUN=0, FREEZE=1, FLUSH=2. The state register resets to RUN.
- Event priority, highest first: reset > ex_busy > branch_taken_ex > load-use > jump_id.
- ex_busy = 1:
  - any_stall=1, bubble_ex=0, flush_if=0.
  - Scoreboard holds. State goes to FREEZE and the watchdog counter increments.
  - When the counter reaches MAX_EX_STALL, watchdog_err is set. It stays set until reset; the stall continues.
  - When ex_busy drops, the counter clears and the state returns to RUN.
  - A branch_taken_ex that arrives during FREEZE is acted on only in the first non-busy cycle.
- branch_taken_ex, not busy:
  - flush_if=1, bubble_ex=1, any_stall=0.
  - SB_EX <= bubble, SB_ME <= SB_EX.
  - If FLUSH_CYC > 1, enter FLUSH and hold flush_if for FLUSH_CYC-1 further cycles, then return to RUN.
  - A load-use in the same cycle is ignored, because the decode instruction is squashed.
- Load-use, not busy, no branch:
  - any_stall=1 for exactly one cycle, bubble_ex=1.
  - SB_EX <= bubble, SB_ME <= SB_EX.
  - Next cycle the load sits in ME and forwarding selects 11.
- jump_id alone: flush_if=1 for one cycle, no stall.
  - SB_EX <= decode entry, SB_ME <= SB_EX.
- Normal advance:
  - SB_EX <= {id_valid & !flush_if_prev, id_reg_write, id_mem_to_reg, id_write_reg}.
  - SB_ME <= SB_EX.
- In FLUSH state, a new branch_taken_ex restarts the flush count. ex_busy still overrides.
- While reset is asserted all outputs are 0. Reset mid-stall or mid-flush returns to RUN next cycle with an empty scoreboard.
- The watchdog counter is $clog2(MAX_EX_STALL+1) bits wide and saturates; it does not wrap.

Decomposition:
- Package pipe_pkg holds:
  - FWD_RF/FWD_EX/FWD_ME/FWD_MELD encodings.
  - The FSM state enum.
  - The scoreboard-entry struct.
- One sub-module, hazard_sb_entry: registered scoreboard stage with hold/bubble/load controls, instantiated twice.

Test Plan:
- lw r2 followed by add r3,r2,r4 -> cycle 1: any_stall=1, bubble_ex=1, fwd=00; cycle 2: any_stall=0, fwd_a_sel=11.
- add r5 in EX, then sub r6,r5,r5 -> fwd_a_sel=fwd_b_sel=01 with no stall. One cycle later, with the add in ME and an independent instruction between them -> 10.
- Write to r0 in EX, then a reader of r0 -> fwd 00, no stall.
- branch_taken_ex with FLUSH_CYC=2 -> flush_if high 2 cycles, bubble_ex 1 cycle, state FLUSH then RUN, SB_EX invalid.
- ex_busy held 40 cycles with MAX_EX_STALL=32 -> any_stall high all 40 cycles, watchdog_err rises at cycle 32 and stays high after ex_busy drops. Only reset clears it.
- Load-use plus branch_taken_ex in the same cycle -> no stall, flush_if=1; then assert reset mid-FLUSH -> all outputs 0, state RUN.
